// File: rtl/pipeline_credit_sink.sv
// Credit-managed result sink for a fixed-latency, valid-only pipeline with an in-order result FIFO.
// Optional issue/return latency checker: define PIPELINE_CREDIT_SINK_LATENCY_CHECK_EN.
module pipeline_credit_sink #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int LATENCY    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         in_ready,
   output logic                         pipe_input_valid,
   output logic [DATA_WIDTH-1:0]        pipe_x,
   input  logic                         pipe_output_valid,
   input  logic [DATA_WIDTH-1:0]        pipe_out,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   inflight,
   output logic                         proto_err,
   output logic                         latency_err
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 1) begin : g_bad_cfg
      $error("pipeline_credit_sink: DEPTH must be a power of two >= 2 and LATENCY >= 1");
   end

   logic [CW-1:0]         inflight_q, count_q;
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  issue, ret, pop, proto_err_q;

   // Credits are taken from registered state only, so in_ready never sees out_ready or returns.
   assign in_ready         = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW + 1)'(DEPTH);
   assign issue            = in_valid & in_ready;
   assign pipe_input_valid = issue;
   assign pipe_x           = in_data;

   // A return with nothing outstanding is dropped rather than corrupting the FIFO.
   assign ret       = pipe_output_valid & (inflight_q != '0);
   assign out_valid = (count_q != '0);
   assign out_data  = mem[rd_ptr];
   assign pop       = out_valid & out_ready;
   assign inflight  = inflight_q;
   assign proto_err = proto_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q  <= '0;
         count_q     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         case ({issue, ret})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: inflight_q <= inflight_q;
         endcase
         case ({ret, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (ret) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (pipe_output_valid && inflight_q == '0) proto_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ret) mem[wr_ptr] <= pipe_out;
   end

`ifdef PIPELINE_CREDIT_SINK_LATENCY_CHECK_EN
   logic [LATENCY:1] vld_pipe;
   logic [LATENCY:0] vld_nxt;
   logic             latency_err_q;

   assign vld_nxt     = {vld_pipe, issue};
   assign latency_err = latency_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe      <= '0;
         latency_err_q <= 1'b0;
      end else begin
         vld_pipe <= vld_nxt[LATENCY-1:0];
         if (pipe_output_valid != vld_pipe[LATENCY]) latency_err_q <= 1'b1;
      end
   end
`else
   assign latency_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_credit_sink.sv
// Directed self-checking bench for pipeline_credit_sink with a 2-cycle "+1" pipeline model.
module tb_pipeline_credit_sink;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid, in_ready, pipe_input_valid, pipe_output_valid;
   logic [DW-1:0] in_data, pipe_x, pipe_out, out_data;
   logic          out_valid, out_ready, proto_err, latency_err;
   logic [2:0]    inflight;

   logic          auto_en = 1'b1, force_v = 1'b0;
   logic [DW-1:0] force_d = '0;
   logic          dv1 = 1'b0, dv2 = 1'b0;
   logic [DW-1:0] dd1 = '0, dd2 = '0;

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_v;
   int n_iss;
   logic [DW-1:0] next_d;
   logic lat_exp;

   pipeline_credit_sink #(.DATA_WIDTH(DW), .DEPTH(4), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .pipe_input_valid(pipe_input_valid), .pipe_x(pipe_x),
      .pipe_output_valid(pipe_output_valid), .pipe_out(pipe_out),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .inflight(inflight), .proto_err(proto_err), .latency_err(latency_err)
   );

   always #5 clk = ~clk;

   // Valid-only pipeline model: returns operand+1 exactly two cycles after issue.
   always @(posedge clk) begin
      dv1 <= pipe_input_valid;
      dv2 <= dv1;
      dd1 <= pipe_x;
      dd2 <= dd1;
   end
   assign pipe_output_valid = (auto_en & dv2) | force_v;
   assign pipe_out          = force_v ? force_d : dd2 + 32'd1;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef PIPELINE_CREDIT_SINK_LATENCY_CHECK_EN
      lat_exp = 1'b1;
`else
      lat_exp = 1'b0;
`endif
      rst = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_piv",       32'(pipe_input_valid), 32'd1);
      chk("rst_in_ready",  32'(in_ready),         32'd1);
      chk("rst_out_valid", 32'(out_valid),        32'd0);
      chk("rst_inflight",  32'(inflight),         32'd0);
      chk("rst_proto",     32'(proto_err),        32'd0);
      chk("rst_lat",       32'(latency_err),      32'd0);
      tick(); in_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // Single op: 5 -> 6, visible LATENCY+1 cycles after issue
      in_valid = 1'b1; in_data = 32'd5; #1;
      chk("single_piv", 32'(pipe_input_valid), 32'd1);
      chk("single_px",  pipe_x,                32'd5);
      tick(); in_valid = 1'b0;
      chk("single_inf1", 32'(inflight),  32'd1);
      chk("single_ov1",  32'(out_valid), 32'd0);
      tick();
      chk("single_ov2",  32'(out_valid), 32'd0);
      chk("single_inf2", 32'(inflight),  32'd1);
      tick();
      chk("single_ov3",  32'(out_valid), 32'd1);
      chk("single_od",   out_data,       32'd6);
      chk("single_inf3", 32'(inflight),  32'd0);
      out_ready = 1'b1;
      tick(); out_ready = 1'b0;
      chk("single_pop", 32'(out_valid), 32'd0);
      tick();

      // Fill with no downstream drain
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 32'(10 + i); #1;
         chk("fill_rdy", 32'(in_ready), 32'd1);
         exp_q.push_back(32'(11 + i));
         tick();
      end
      in_valid = 1'b1; in_data = 32'd14; #1;
      chk("fill_blk_rdy", 32'(in_ready),         32'd0);
      chk("fill_blk_piv", 32'(pipe_input_valid), 32'd0);
      tick(); tick();
      chk("full_ov",    32'(out_valid), 32'd1);
      chk("full_head",  out_data,       32'd11);
      chk("full_rdy",   32'(in_ready),  32'd0);
      chk("full_inf",   32'(inflight),  32'd0);
      chk("full_proto", 32'(proto_err), 32'd0);
      out_ready = 1'b1;
      exp_v = exp_q.pop_front();
      tick();
      chk("credit_back", 32'(in_ready), 32'd1);
      chk("next_head",   out_data,      32'd12);

      // Stream to 12 total ops with irregular drain; pointers wrap
      n_iss = 4; next_d = 32'd14;
      for (int c = 0; c < 80; c++) begin
         in_valid = (n_iss < 12); in_data = next_d; out_ready = (c % 3 != 1);
         #1;
         if (pipe_input_valid) begin
            exp_q.push_back(next_d + 32'd1);
            next_d = next_d + 32'd1;
            n_iss++;
         end
         if (out_valid && out_ready) begin
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk("order", out_data, exp_v);
         end
         tick();
         if (n_iss == 12 && exp_q.size() == 0) break;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("stream_issued", 32'(n_iss),        32'd12);
      chk("stream_drain",  32'(exp_q.size()), 32'd0);
      tick();
      chk("stream_ov",    32'(out_valid),   32'd0);
      chk("stream_inf",   32'(inflight),    32'd0);
      chk("stream_proto", 32'(proto_err),   32'd0);
      chk("stream_lat",   32'(latency_err), 32'd0);

      // Spurious return with nothing outstanding
      force_v = 1'b1; force_d = 32'hDEAD_BEEF;
      tick(); force_v = 1'b0;
      chk("spur_proto", 32'(proto_err), 32'd1);
      chk("spur_ov",    32'(out_valid), 32'd0);
      chk("spur_inf",   32'(inflight),  32'd0);
      tick();
      chk("spur_sticky", 32'(proto_err), 32'd1);
      chk("spur_ov2",    32'(out_valid), 32'd0);

      // Mid-run reset discards stored and in-flight results
      rst = 1'b1; tick(); rst = 1'b0; #1;
      chk("clr_proto", 32'(proto_err), 32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 32'(20 + i);
         tick();
      end
      in_valid = 1'b0;
      chk("mid_ov_pre",  32'(out_valid), 32'd1);
      chk("mid_inf_pre", 32'(inflight),  32'd2);
      rst = 1'b1; #1;
      chk("mid_ov",  32'(out_valid), 32'd0);
      chk("mid_inf", 32'(inflight),  32'd0);
      chk("mid_rdy", 32'(in_ready),  32'd1);
      tick(); rst = 1'b0;
      tick();
      chk("late_proto", 32'(proto_err), 32'd1);
      chk("late_ov",    32'(out_valid), 32'd0);
      chk("late_inf",   32'(inflight),  32'd0);

      // Return delayed to LATENCY+1
      rst = 1'b1; auto_en = 1'b0; tick(); rst = 1'b0; tick();
      in_valid = 1'b1; in_data = 32'd30;
      tick(); in_valid = 1'b0;
      tick(); tick();
      force_v = 1'b1; force_d = 32'd31;
      tick(); force_v = 1'b0;
      chk("lat_err",   32'(latency_err), 32'(lat_exp));
      chk("lat_ov",    32'(out_valid),   32'd1);
      chk("lat_od",    out_data,         32'd31);
      chk("lat_proto", 32'(proto_err),   32'd0);
      rst = 1'b1; #1;
      chk("lat_clr", 32'(latency_err), 32'd0);
      tick(); rst = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
